gat_host_load_ctrl: RTL and testbench
=====================================

# gat_host_load_ctrl

Multi-channel host-to-BRAM load controller and layer sequencer for the GAT accelerator. It accepts byte-addressed 32-bit host writes per channel and packs them into wide BRAM entries. It counts committed entries against programmed targets and issues per-layer `core_start` pulses, so multi-layer inference runs without host polling. It sits between the AXI BRAM controllers / register bank and the `gat_top` core, and generalises the fixed three-port, single-layer top-level wrapper.

## Interface
- `TOP_WIDTH`, 32: host data width; must be 32.
- `NUM_CH`, 3: number of load channels (H data, node info, weights, ...).
- `ENTRY_WIDTH`, 64: packed BRAM entry width. The same width is used for all channels; consumers slice the LSBs they need.
- `ADDR_W`, 18: entry address width.
- `LAYER_W`, 2: layer counter width.
- Derived: `WPE = ceil(ENTRY_WIDTH/TOP_WIDTH)`, `LANE_W = max(1, clog2(WPE))`, `HADDR_W = ADDR_W+LANE_W+2`, `CNT_W = ADDR_W+1`.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `host_start` in 1: one-cycle pulse that begins a job.
- `host_load_done` in NUM_CH: register-bank level flag per channel.
- `cfg_num_entries` in NUM_CH*CNT_W: expected entries per channel.
- `cfg_num_layers` in LAYER_W: number of layers minus 1.
- `host_din` in NUM_CH*TOP_WIDTH, `host_ena`/`host_wea` in NUM_CH, `host_addra` in NUM_CH*HADDR_W: byte-addressed host write ports.
- `bram_din` out NUM_CH*ENTRY_WIDTH, `bram_wea` out NUM_CH, `bram_addra` out NUM_CH*ADDR_W: packed write ports.
- `core_start` out 1: one-cycle start pulse.
- `core_layer` out LAYER_W: current layer index.
- `core_done` in 1: one-cycle pulse from the core.
- `gat_ready` out 1: job complete.
- `gat_debug` out 32: {state[31:30], layer[29:28], err_part[27], err_ovf[26], err_state[25], 0[24:19], cnt_ch0[18:0] zero-extended/truncated}.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE→LOAD on `host_start`.
  - LOAD→RUN when every channel has count == cfg and `host_load_done`=1.
  - RUN→LOAD on `core_done` if layer < cfg_num_layers; layer increments and counts clear. This lets the host reload weights/features per layer.
  - RUN→DONE on `core_done` at the last layer.
  - DONE→LOAD on `host_start`; layer and counts clear, error flags clear.
- Address decode per channel: `word = host_addra[HADDR_W-1:2]`; lane = `word[LANE_W-1:0]` (always 0 if WPE=1); entry = `word[HADDR_W-3:LANE_W]`.
- Host write (ena & wea) in LOAD: store din into lane slot, set lane mask bit, latch entry address. When the mask becomes all-ones, commit: `bram_wea`=1 with the assembled entry, mask clears, count+1.
- Partial entry pending and a write arrives to a different entry: discard the old partial (mask reset to the new lane only) and set sticky `err_part`.
- Commit when count == cfg: the write is dropped, count holds, and sticky `err_ovf` is set.
- Host write outside LOAD: ignored, sticky `err_state` set.
- Rewriting the same lane before commit: data overwritten, no error.
- Reads are out of scope; the feature BRAM read port is wired outside this block.

## Timing
- Reset values: all outputs 0, state IDLE, layer 0, masks/counts/flags 0.
- Host write at edge t → `bram_wea`/`bram_din`/`bram_addra` valid for exactly one cycle after edge t+1 (1-cycle latency). The count updates at the same edge.
- The LOAD exit check uses registered counts, so RUN is entered 1 cycle after the final commit at the earliest. `core_start` pulses in the first RUN cycle.
- `core_layer` is stable from LOAD entry through RUN.
- `gat_ready`=1 only in DONE.
- `core_done` outside RUN is ignored.
- `host_start` in LOAD/RUN is ignored.
- Channels are fully independent. Simultaneous commits on all channels in one cycle are required to work.
- `rst_n` asserted mid-job: immediate return to reset values; pending partial entries are lost.

## Structure
- Package `gat_load_pkg`: state enum, WPE/LANE_W/CNT_W derivation functions, debug bit-position constants.
- Sub-module `gat_entry_packer` (one per channel via generate): lane mask, assembly register, commit, count, per-channel error flags. The top holds the FSM, layer counter and debug mux.

## Test plan
- ENTRY_WIDTH=64, cfg=4 on all channels: host_start, write 8 sequential words per channel (addr 0x00..0x1C), load_done=1 → four bram writes per channel at addr 0..3 with {word1,word0} packing; core_start pulses once; core_layer=0.
- Lanes written in reverse order (0x04 then 0x00) → single commit with the correct packing.
- Write 0x00, then 0x08 → err_part=1 (gat_debug[27]); entry 0 never committed.
- cfg=2, three full entries written → third dropped, count=2, err_ovf=1.
- cfg_num_layers=1: core_done in RUN → LOAD, layer=1, counts 0; reload; second core_done → DONE, gat_ready=1.
- rst_n low during LOAD with half an entry pending → all outputs 0; after release, a fresh job completes normally.

Source files
------------

// File: rtl/gat_load_pkg.sv
// gat_load_pkg: shared state enum, width derivation functions and debug word bit positions for the GAT load controller
package gat_load_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  function automatic int calc_wpe(input int ew, input int tw);
    return (ew + tw - 1) / tw;
  endfunction
  function automatic int calc_lane_w(input int wpe);
    return wpe > 1 ? $clog2(wpe) : 1;
  endfunction
  function automatic int calc_cnt_w(input int aw);
    return aw + 1;
  endfunction
  localparam int DBG_STATE     = 30;
  localparam int DBG_LAYER     = 28;
  localparam int DBG_ERR_PART  = 27;
  localparam int DBG_ERR_OVF   = 26;
  localparam int DBG_ERR_STATE = 25;
  localparam int DBG_CNT_W     = 19;
endpackage

// File: rtl/gat_entry_packer.sv
// gat_entry_packer: packs byte-addressed host words into wide BRAM entries (ports: host write in, packed write out, committed count, sticky errors)
module gat_entry_packer import gat_load_pkg::*; #(
  parameter int TOP_WIDTH = 32,
  parameter int ENTRY_WIDTH = 64,
  parameter int ADDR_W = 18,
  localparam int WPE = calc_wpe(ENTRY_WIDTH, TOP_WIDTH),
  localparam int LANE_W = calc_lane_w(WPE),
  localparam int HADDR_W = ADDR_W + LANE_W + 2,
  localparam int CNT_W = calc_cnt_w(ADDR_W)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_cnt,
  input  logic                   clr_err,
  input  logic                   load,
  input  logic [CNT_W-1:0]       cfg,
  input  logic [TOP_WIDTH-1:0]   din,
  input  logic                   ena,
  input  logic                   wea,
  input  logic [HADDR_W-1:0]     addra,
  output logic [ENTRY_WIDTH-1:0] bram_din,
  output logic                   bram_wea,
  output logic [ADDR_W-1:0]      bram_addra,
  output logic [CNT_W-1:0]       count,
  output logic                   err_part,
  output logic                   err_ovf,
  output logic                   err_state
);
  logic [WPE-1:0] mask, lane_bit, mask_nx;
  logic [WPE*TOP_WIDTH-1:0] data, data_nx;
  logic [ADDR_W-1:0] entry, cur;
  logic [LANE_W-1:0] lane;
  logic wr, diff, full;
  always_comb begin
    lane = WPE == 1 ? '0 : addra[LANE_W+1:2];
    entry = addra[HADDR_W-1:LANE_W+2];
    lane_bit = WPE'(1) << lane;
    wr = ena & wea;
    diff = (|mask) & (entry != cur);
    mask_nx = (diff ? '0 : mask) | lane_bit;
    full = &mask_nx;
    data_nx = data;
    data_nx[lane*TOP_WIDTH +: TOP_WIDTH] = din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
      data <= '0;
      cur <= '0;
      count <= '0;
      bram_wea <= 1'b0;
      bram_din <= '0;
      bram_addra <= '0;
      err_part <= 1'b0;
      err_ovf <= 1'b0;
      err_state <= 1'b0;
    end else begin
      bram_wea <= 1'b0;
      if (clr_err) begin
        err_part <= 1'b0;
        err_ovf <= 1'b0;
        err_state <= 1'b0;
      end
      if (clr_cnt) begin
        mask <= '0;
        count <= '0;
      end else if (wr && !load) begin
        err_state <= 1'b1;
      end else if (wr) begin
        data <= data_nx;
        cur <= entry;
        if (diff) err_part <= 1'b1;
        if (!full) begin
          mask <= mask_nx;
        end else begin
          mask <= '0;
          if (count == cfg) begin
            err_ovf <= 1'b1;
          end else begin
            bram_wea <= 1'b1;
            bram_din <= data_nx[ENTRY_WIDTH-1:0];
            bram_addra <= entry;
            count <= count + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/gat_host_load_ctrl.sv
// gat_host_load_ctrl: multi-channel host-to-BRAM loader and layer sequencer (ports: host job/write inputs, packed BRAM writes, core start/done handshake, ready and debug)
module gat_host_load_ctrl import gat_load_pkg::*; #(
  parameter int TOP_WIDTH = 32,
  parameter int NUM_CH = 3,
  parameter int ENTRY_WIDTH = 64,
  parameter int ADDR_W = 18,
  parameter int LAYER_W = 2,
  localparam int WPE = calc_wpe(ENTRY_WIDTH, TOP_WIDTH),
  localparam int LANE_W = calc_lane_w(WPE),
  localparam int HADDR_W = ADDR_W + LANE_W + 2,
  localparam int CNT_W = calc_cnt_w(ADDR_W)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          host_start,
  input  logic [NUM_CH-1:0]             host_load_done,
  input  logic [NUM_CH*CNT_W-1:0]       cfg_num_entries,
  input  logic [LAYER_W-1:0]            cfg_num_layers,
  input  logic [NUM_CH*TOP_WIDTH-1:0]   host_din,
  input  logic [NUM_CH-1:0]             host_ena,
  input  logic [NUM_CH-1:0]             host_wea,
  input  logic [NUM_CH*HADDR_W-1:0]     host_addra,
  output logic [NUM_CH*ENTRY_WIDTH-1:0] bram_din,
  output logic [NUM_CH-1:0]             bram_wea,
  output logic [NUM_CH*ADDR_W-1:0]      bram_addra,
  output logic                          core_start,
  output logic [LAYER_W-1:0]            core_layer,
  input  logic                          core_done,
  output logic                          gat_ready,
  output logic [31:0]                   gat_debug
);
  state_t state;
  logic [LAYER_W-1:0] layer;
  logic [NUM_CH-1:0][CNT_W-1:0] count;
  logic [NUM_CH-1:0] cnt_ok, e_part, e_ovf, e_state;
  logic start_job, next_layer, clr_cnt, load, all_done;
  logic [CNT_W+DBG_CNT_W-1:0] cnt_ext;
  logic [LAYER_W+1:0] layer_ext;
  always_comb begin
    start_job = host_start & ((state == IDLE) | (state == DONE));
    next_layer = (state == RUN) & core_done & (layer < cfg_num_layers);
    clr_cnt = start_job | next_layer;
    load = state == LOAD;
    all_done = &(cnt_ok & host_load_done);
    cnt_ext = {{DBG_CNT_W{1'b0}}, count[0]};
    layer_ext = {2'b00, layer};
    gat_debug = '0;
    gat_debug[DBG_STATE +: 2] = state;
    gat_debug[DBG_LAYER +: 2] = layer_ext[1:0];
    gat_debug[DBG_ERR_PART] = |e_part;
    gat_debug[DBG_ERR_OVF] = |e_ovf;
    gat_debug[DBG_ERR_STATE] = |e_state;
    gat_debug[DBG_CNT_W-1:0] = cnt_ext[DBG_CNT_W-1:0];
  end
  assign core_layer = layer;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gat_entry_packer #(
      .TOP_WIDTH(TOP_WIDTH),
      .ENTRY_WIDTH(ENTRY_WIDTH),
      .ADDR_W(ADDR_W)
    ) u_packer (
      .clk(clk),
      .rst_n(rst_n),
      .clr_cnt(clr_cnt),
      .clr_err(start_job),
      .load(load),
      .cfg(cfg_num_entries[i*CNT_W +: CNT_W]),
      .din(host_din[i*TOP_WIDTH +: TOP_WIDTH]),
      .ena(host_ena[i]),
      .wea(host_wea[i]),
      .addra(host_addra[i*HADDR_W +: HADDR_W]),
      .bram_din(bram_din[i*ENTRY_WIDTH +: ENTRY_WIDTH]),
      .bram_wea(bram_wea[i]),
      .bram_addra(bram_addra[i*ADDR_W +: ADDR_W]),
      .count(count[i]),
      .err_part(e_part[i]),
      .err_ovf(e_ovf[i]),
      .err_state(e_state[i])
    );
    assign cnt_ok[i] = count[i] == cfg_num_entries[i*CNT_W +: CNT_W];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      layer <= '0;
      core_start <= 1'b0;
      gat_ready <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: if (host_start) state <= LOAD;
        LOAD: if (all_done) begin
          state <= RUN;
          core_start <= 1'b1;
        end
        RUN: if (core_done) begin
          if (next_layer) begin
            layer <= layer + 1'b1;
            state <= LOAD;
          end else begin
            state <= DONE;
            gat_ready <= 1'b1;
          end
        end
        DONE: if (host_start) begin
          state <= LOAD;
          layer <= '0;
          gat_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gat_host_load_ctrl.sv
// tb_gat_host_load_ctrl: directed scoreboard bench for the GAT host load controller
module tb_gat_host_load_ctrl;
  logic clk = 0, rst_n = 0, host_start = 0, core_done = 0;
  logic [2:0] host_load_done = 0, host_ena = 0, host_wea = 0, bram_wea;
  logic [56:0] cfg_num_entries = 0;
  logic [1:0] cfg_num_layers = 0, core_layer;
  logic [95:0] host_din = 0;
  logic [62:0] host_addra = 0;
  logic [191:0] bram_din;
  logic [53:0] bram_addra;
  logic core_start, gat_ready;
  logic [31:0] gat_debug;
  int checks = 0, errors = 0, starts = 0;
  typedef struct packed {logic [17:0] a; logic [63:0] d;} exp_t;
  exp_t q[3][$];
  always #5 clk = ~clk;
  gat_host_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .host_start(host_start), .host_load_done(host_load_done),
    .cfg_num_entries(cfg_num_entries), .cfg_num_layers(cfg_num_layers),
    .host_din(host_din), .host_ena(host_ena), .host_wea(host_wea), .host_addra(host_addra),
    .bram_din(bram_din), .bram_wea(bram_wea), .bram_addra(bram_addra),
    .core_start(core_start), .core_layer(core_layer), .core_done(core_done),
    .gat_ready(gat_ready), .gat_debug(gat_debug)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] dw(input int ch, input int k);
    return 32'hA000_0000 + (32'(ch) << 28) + 32'(k);
  endfunction
  task automatic push(input int ch, input int e);
    exp_t x;
    x.a = 18'(e);
    x.d = {dw(ch, 2*e+1), dw(ch, 2*e)};
    q[ch].push_back(x);
  endtask
  task automatic wr(input logic [2:0] en, input int a);
    for (int c = 0; c < 3; c++) begin
      host_addra[c*21 +: 21] = 21'(a);
      host_din[c*32 +: 32] = dw(c, a/4);
    end
    host_ena = en;
    host_wea = en;
    @(posedge clk); #1;
    host_ena = 0;
    host_wea = 0;
  endtask
  task automatic pulse_start();
    host_start = 1; @(posedge clk); #1; host_start = 0;
  endtask
  task automatic pulse_done();
    core_done = 1; @(posedge clk); #1; core_done = 0;
  endtask
  task automatic wait_start(input int exp);
    for (int i = 0; i < 20 && starts < exp; i++) @(negedge clk);
    @(negedge clk);
    chk("core_start_pulses", 64'(starts), 64'(exp));
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (core_start) starts++;
    for (int c = 0; c < 3; c++) if (bram_wea[c]) begin
      if (q[c].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bram_unexpected ch%0d actual addr=%h data=%h required none", c, bram_addra[c*18 +: 18], bram_din[c*64 +: 64]);
      end else begin
        e = q[c].pop_front();
        chk($sformatf("bram_addr_ch%0d", c), 64'(bram_addra[c*18 +: 18]), 64'(e.a));
        chk($sformatf("bram_data_ch%0d", c), bram_din[c*64 +: 64], e.d);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_debug", 64'(gat_debug), 0);
    chk("rst_outs", {bram_wea, core_start, gat_ready, core_layer}, 0);
    chk("rst_bram", bram_din[63:0] | 64'(bram_addra), 0);
    @(posedge clk); #1 rst_n = 1;
    cfg_num_entries = {19'd4, 19'd4, 19'd4};
    cfg_num_layers = 1;
    pulse_start();
    for (int c = 0; c < 3; c++) for (int e = 0; e < 4; e++) push(c, e);
    for (int a = 0; a < 32; a += 4) wr(3'b111, a);
    @(negedge clk);
    chk("l0_loaded_debug", 64'(gat_debug), 64'h4000_0004);
    host_load_done = 3'b111;
    wait_start(1);
    chk("l0_run_debug", 64'(gat_debug), 64'h8000_0004);
    chk("l0_layer", 64'(core_layer), 0);
    pulse_done();
    @(negedge clk);
    chk("l1_load_debug", 64'(gat_debug), 64'h5000_0000);
    pulse_done();
    pulse_start();
    @(negedge clk);
    chk("ignored_done_start", 64'(gat_debug), 64'h5000_0000);
    for (int c = 0; c < 3; c++) for (int e = 0; e < 4; e++) push(c, e);
    for (int e = 0; e < 4; e++) begin
      wr(3'b111, e*8 + 4);
      wr(3'b111, e*8);
    end
    wait_start(2);
    chk("l1_run_debug", 64'(gat_debug), 64'h9000_0004);
    chk("l1_layer", 64'(core_layer), 1);
    chk("l1_ready_low", 64'(gat_ready), 0);
    pulse_done();
    @(negedge clk);
    chk("done_debug", 64'(gat_debug), 64'hD000_0004);
    chk("done_ready", 64'(gat_ready), 1);
    wr(3'b001, 0);
    wr(3'b001, 4);
    @(negedge clk);
    chk("err_state", 64'(gat_debug), 64'hD200_0004);
    cfg_num_entries = {19'd4, 19'd4, 19'd2};
    pulse_start();
    @(negedge clk);
    chk("jobb_debug", 64'(gat_debug), 64'h4000_0000);
    chk("jobb_ready", 64'(gat_ready), 0);
    wr(3'b010, 0);
    wr(3'b010, 8);
    @(negedge clk);
    chk("err_part", 64'(gat_debug), 64'h4800_0000);
    push(1, 1);
    wr(3'b010, 12);
    push(0, 0);
    push(0, 1);
    for (int a = 0; a < 24; a += 4) wr(3'b001, a);
    @(negedge clk);
    chk("err_ovf", 64'(gat_debug), 64'h4C00_0002);
    wr(3'b100, 0);
    rst_n = 0;
    #1;
    chk("midrst_debug", 64'(gat_debug), 0);
    chk("midrst_outs", {bram_wea, core_start, gat_ready, core_layer}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cfg_num_entries = {19'd1, 19'd1, 19'd1};
    cfg_num_layers = 0;
    pulse_start();
    wr(3'b100, 4);
    @(negedge clk);
    chk("fresh_no_stale", 64'(gat_debug), 64'h4000_0000);
    push(2, 0);
    wr(3'b100, 0);
    push(0, 0);
    push(1, 0);
    wr(3'b011, 0);
    wr(3'b011, 4);
    wait_start(3);
    chk("c_layer", 64'(core_layer), 0);
    pulse_done();
    @(negedge clk);
    chk("c_done_debug", 64'(gat_debug), 64'hC000_0001);
    chk("c_ready", 64'(gat_ready), 1);
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) chk($sformatf("sb_empty_ch%0d", c), 64'(q[c].size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
